// File: rtl/timer_tstamp_fifo.sv
// Timestamp capture FIFO for the timer peripheral.
// Each rising edge of timer_irq_i stores the current 64-bit timer value.
// The CPU sees the oldest entry on ts_high_o/ts_low_o and discards it with pop_i.
// irq_o stays high while any entry is pending.
// Events that arrive while the FIFO is full and no pop is freeing a slot are
// dropped and counted in a saturating counter.
//
// Pop strobe semantics:
//   pop_i is a single-cycle request. It takes effect only when count_o != 0
//   and clear_i is low. A pop on an empty FIFO is ignored silently.
module timer_tstamp_fifo #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 2,
   parameter int OVF_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  timer_irq_i,
   input  logic [2*DATA_W-1:0]   timer_val_i,
   input  logic                  clear_i,
   input  logic                  pop_i,
   output logic [DATA_W-1:0]     ts_low_o,
   output logic [DATA_W-1:0]     ts_high_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic [OVF_W-1:0]      ovf_cnt_o,
   output logic                  irq_o
);

   localparam int TS_W  = 2 * DATA_W;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [TS_W-1:0]       mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [CNT_W-1:0]      count;
   logic [OVF_W-1:0]      ovf_cnt;
   logic                  irq_q;

   logic                  evt;
   logic                  full;
   logic                  do_pop;
   logic                  do_push;
   logic                  do_drop;
   logic [TS_W-1:0]       head;

   // Decode event and push/pop/drop qualifiers; clear overrides everything.
   always_comb begin
      evt     = timer_irq_i & ~irq_q;
      full    = (count == DEPTH_C);
      do_pop  = pop_i & (count != '0) & ~clear_i;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push = evt & ~clear_i & (~full | do_pop);
      do_drop = evt & ~clear_i & full & ~do_pop;
   end

   // Edge-detect register samples the interrupt every cycle, even during clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) irq_q <= 1'b0;
      else      irq_q <= timer_irq_i;
   end

   // Pointers, occupancy and the saturating drop counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         ovf_cnt <= '0;
      end else if (clear_i) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         ovf_cnt <= '0;
      end else begin
         if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
         if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         if (do_drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
   end

   // Storage array; contents need no reset because count gates the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= timer_val_i;
   end

   // Head read and status outputs, all derived from registered state.
   always_comb begin
      head      = (count != '0) ? mem[rptr] : '0;
      ts_low_o  = head[DATA_W-1:0];
      ts_high_o = head[TS_W-1:DATA_W];
      count_o   = count;
      full_o    = full;
      ovf_cnt_o = ovf_cnt;
      irq_o     = (count != '0);
   end

endmodule

// File: tb/tb_timer_tstamp_fifo.sv
// Directed testbench for timer_tstamp_fifo (default parameters, depth 4).
module tb_timer_tstamp_fifo;

   logic        clk;
   logic        rst;
   logic        timer_irq;
   logic [63:0] timer_val;
   logic        clear;
   logic        pop;
   logic [31:0] ts_low;
   logic [31:0] ts_high;
   logic [2:0]  count;
   logic        full;
   logic [7:0]  ovf_cnt;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   timer_tstamp_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .timer_irq_i (timer_irq),
      .timer_val_i (timer_val),
      .clear_i     (clear),
      .pop_i       (pop),
      .ts_low_o    (ts_low),
      .ts_high_o   (ts_high),
      .count_o     (count),
      .full_o      (full),
      .ovf_cnt_o   (ovf_cnt),
      .irq_o       (irq)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle interrupt pulse followed by a low cycle so irq_q returns to 0.
   task automatic pulse(input logic [63:0] v);
      timer_val = v;
      timer_irq = 1'b1;
      step();
      timer_irq = 1'b0;
      step();
   endtask

   task automatic do_pop();
      pop = 1'b1;
      step();
      pop = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      timer_irq = 1'b0;
      timer_val = '0;
      clear = 1'b0;
      pop = 1'b0;
      #1;
      checks++;
      if ({ts_high, ts_low, count, full, ovf_cnt, irq} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got hi=%h lo=%h cnt=%0d full=%b ovf=%0d irq=%b exp all 0",
                  ts_high, ts_low, count, full, ovf_cnt, irq);
      end
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      timer_val = 64'h0000_0001_0000_0010;
      timer_irq = 1'b1;
      step();
      timer_irq = 1'b0;
      checks++;
      if (count !== 3'd1 || irq !== 1'b1) begin
         failures++;
         $display("FAIL single_count got cnt=%0d irq=%b exp cnt=1 irq=1", count, irq);
      end
      checks++;
      if (ts_high !== 32'h1 || ts_low !== 32'h10) begin
         failures++;
         $display("FAIL single_ts got %h_%h exp 00000001_00000010", ts_high, ts_low);
      end
      step();
      do_pop();
      checks++;
      if (count !== 3'd0 || irq !== 1'b0 || ts_high !== 32'h0 || ts_low !== 32'h0) begin
         failures++;
         $display("FAIL single_pop got cnt=%0d irq=%b ts=%h_%h exp 0", count, irq, ts_high, ts_low);
      end
      // Pop on empty is ignored.
      do_pop();
      checks++;
      if (count !== 3'd0 || ovf_cnt !== 8'd0) begin
         failures++;
         $display("FAIL empty_pop got cnt=%0d ovf=%0d exp 0 0", count, ovf_cnt);
      end
   endtask

   task automatic test_level_held();
      timer_irq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         timer_val = 64'(100 + i);
         step();
      end
      timer_irq = 1'b0;
      checks++;
      if (count !== 3'd1 || ts_low !== 32'd100) begin
         failures++;
         $display("FAIL level_held got cnt=%0d lo=%0d exp cnt=1 lo=100", count, ts_low);
      end
      step();
      do_pop();
   endtask

   task automatic test_fill_overflow();
      for (int v = 1; v <= 6; v++) begin
         pulse(64'(v));
         if (v <= 4) exp_q.push_back(32'(v));
      end
      checks++;
      if (full !== 1'b1 || count !== 3'd4 || ovf_cnt !== 8'd2) begin
         failures++;
         $display("FAIL overflow_state got full=%b cnt=%0d ovf=%0d exp 1 4 2", full, count, ovf_cnt);
      end
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         checks++;
         if (ts_low !== e || ts_high !== 32'h0) begin
            failures++;
            $display("FAIL overflow_pop got %h_%h exp 00000000_%h", ts_high, ts_low, e);
         end
         do_pop();
      end
      checks++;
      if (count !== 3'd0 || ovf_cnt !== 8'd2 || full !== 1'b0) begin
         failures++;
         $display("FAIL overflow_drained got cnt=%0d ovf=%0d full=%b exp 0 2 0", count, ovf_cnt, full);
      end
   endtask

   task automatic test_push_pop_full();
      do_clear();
      for (int v = 1; v <= 4; v++) pulse(64'(v));
      timer_val = 64'd5;
      timer_irq = 1'b1;
      pop = 1'b1;
      step();
      timer_irq = 1'b0;
      pop = 1'b0;
      checks++;
      if (count !== 3'd4 || ovf_cnt !== 8'd0 || full !== 1'b1) begin
         failures++;
         $display("FAIL full_pushpop got cnt=%0d ovf=%0d full=%b exp 4 0 1", count, ovf_cnt, full);
      end
      step();
      for (int v = 2; v <= 5; v++) exp_q.push_back(32'(v));
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         checks++;
         if (ts_low !== e) begin
            failures++;
            $display("FAIL full_pushpop_pop got %0d exp %0d", ts_low, e);
         end
         do_pop();
      end
   endtask

   task automatic test_clear_with_event();
      for (int v = 1; v <= 5; v++) pulse(64'(32'h30 + v));
      do_pop();
      checks++;
      if (count !== 3'd3 || ovf_cnt !== 8'd1) begin
         failures++;
         $display("FAIL clear_setup got cnt=%0d ovf=%0d exp 3 1", count, ovf_cnt);
      end
      timer_val = 64'h77;
      timer_irq = 1'b1;
      clear = 1'b1;
      step();
      timer_irq = 1'b0;
      clear = 1'b0;
      checks++;
      if (count !== 3'd0 || ovf_cnt !== 8'd0 || irq !== 1'b0 || ts_low !== 32'h0) begin
         failures++;
         $display("FAIL clear_event got cnt=%0d ovf=%0d irq=%b lo=%h exp 0 0 0 0", count, ovf_cnt, irq, ts_low);
      end
      step();
      checks++;
      if (count !== 3'd0) begin
         failures++;
         $display("FAIL clear_no_write got cnt=%0d exp 0", count);
      end
      pulse(64'h88);
      checks++;
      if (count !== 3'd1 || ts_low !== 32'h88) begin
         failures++;
         $display("FAIL clear_after got cnt=%0d lo=%h exp 1 88", count, ts_low);
      end
      do_pop();
   endtask

   task automatic test_async_reset_wrap();
      pulse(64'hA1);
      pulse(64'hA2);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({ts_high, ts_low, count, full, ovf_cnt, irq} !== '0) begin
         failures++;
         $display("FAIL async_reset got hi=%h lo=%h cnt=%0d full=%b ovf=%0d irq=%b exp all 0",
                  ts_high, ts_low, count, full, ovf_cnt, irq);
      end
      step();
      rst = 1'b1;
      step();
      for (int i = 0; i < 9; i++) begin
         logic [63:0] v;
         v = {32'(i + 7), 32'(32'hC0 + i)};
         timer_val = v;
         timer_irq = 1'b1;
         step();
         timer_irq = 1'b0;
         checks++;
         if (count !== 3'd1 || {ts_high, ts_low} !== v) begin
            failures++;
            $display("FAIL wrap_%0d got cnt=%0d ts=%h_%h exp cnt=1 ts=%h", i, count, ts_high, ts_low, v);
         end
         do_pop();
      end
      checks++;
      if (count !== 3'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL wrap_end got cnt=%0d irq=%b exp 0 0", count, irq);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_level_held();
      test_fill_overflow();
      test_push_pop_full();
      test_clear_with_event();
      test_async_reset_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
